// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational decode captured into a registered
// output slot backed by a one-entry skid register, valid/ready on both sides.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter bit EN_M      = 1'b1,
  parameter bit EN_SYSTEM = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_opcode,
  output logic [6:0]      o_funct7,
  output logic [2:0]      o_funct3,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_type,
  output logic            o_illegal
);

  typedef enum logic [2:0] {
    T_ERROR = 3'd0,
    T_R     = 3'd1,
    T_I     = 3'd2,
    T_S     = 3'd3,
    T_B     = 3'd4,
    T_U     = 3'd5,
    T_J     = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    fmt_e            typ;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam bit IS64 = (XLEN == 64);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [31:0] inst;
  logic [6:0]  op;
  logic [6:0]  f7;
  logic [2:0]  f3;

  assign inst = i_instruction;
  assign op   = inst[6:0];
  assign f7   = inst[31:25];
  assign f3   = inst[14:12];

  // Alternate funct7 (sub/sra) only exists for funct3 000 and 101.
  logic r_funct_ok;
  logic shift_ok;

  assign r_funct_ok = (f7 == 7'b0000000)
                   || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                   || (EN_M && f7 == 7'b0000001);

  // RV64 shift amounts are 6 bits wide, so only inst[31:26] carries funct bits.
  always_comb begin
    if (IS64) begin
      shift_ok = (inst[31:26] == 6'b000000)
              || (inst[31:26] == 6'b010000 && f3 == 3'b101);
    end else begin
      shift_ok = (f7 == 7'b0000000)
              || (f7 == 7'b0100000 && f3 == 3'b101);
    end
  end

  fmt_e fmt;
  logic bad;

  // NOTE: every variable gets a default before the case, otherwise an
  // unassigned path turns it into a latch.
  always_comb begin
    fmt = T_ERROR;
    bad = 1'b0;
    case (op)
      OP_OP: begin
        fmt = T_R;
        bad = !r_funct_ok;
      end
      OP_OP32: begin
        if (IS64) begin
          fmt = T_R;
          bad = !r_funct_ok;
        end
      end
      OP_IMM: begin
        fmt = T_I;
        if (f3 == 3'b001 || f3 == 3'b101) bad = !shift_ok;
      end
      OP_IMM32: begin
        if (IS64) fmt = T_I;
      end
      OP_LOAD: begin
        fmt = T_I;
        bad = (f3 == 3'b111) || (!IS64 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OP_JALR: begin
        fmt = T_I;
        bad = (f3 != 3'b000);
      end
      OP_SYSTEM: begin
        if (EN_SYSTEM) fmt = T_I;
      end
      OP_STORE: begin
        fmt = T_S;
        bad = (f3 >= 3'b100) || (!IS64 && f3 == 3'b011);
      end
      OP_BRANCH: begin
        fmt = T_B;
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LUI, OP_AUIPC: fmt = T_U;
      OP_JAL:           fmt = T_J;
      default:          fmt = T_ERROR;
    endcase
    if (inst[1:0] != 2'b11) bad = 1'b1;
  end

  entry_t dec;

  // Illegal entries keep only pc and opcode so downstream can trap on them.
  always_comb begin
    dec        = '0;
    dec.pc     = i_pc;
    dec.opcode = op;
    if (bad || fmt == T_ERROR) begin
      dec.typ     = T_ERROR;
      dec.illegal = 1'b1;
    end else begin
      dec.typ = fmt;
      case (fmt)
        T_R: begin
          dec.funct7 = f7;
          dec.funct3 = f3;
          dec.rs1    = inst[19:15];
          dec.rs2    = inst[24:20];
          dec.rd     = inst[11:7];
        end
        T_I: begin
          dec.funct3 = f3;
          dec.rs1    = inst[19:15];
          dec.rd     = inst[11:7];
          dec.imm    = sext32({{20{inst[31]}}, inst[31:20]});
        end
        T_S: begin
          dec.funct3 = f3;
          dec.rs1    = inst[19:15];
          dec.rs2    = inst[24:20];
          dec.imm    = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
        end
        T_B: begin
          dec.funct3 = f3;
          dec.rs1    = inst[19:15];
          dec.rs2    = inst[24:20];
          dec.imm    = sext32({{19{inst[31]}}, inst[31], inst[7],
                               inst[30:25], inst[11:8], 1'b0});
        end
        T_U: begin
          dec.rd  = inst[11:7];
          dec.imm = sext32({inst[31:12], 12'b0});
        end
        T_J: begin
          dec.rd  = inst[11:7];
          dec.imm = sext32({{11{inst[31]}}, inst[31], inst[19:12],
                            inst[20], inst[30:21], 1'b0});
        end
        default: dec = dec;
      endcase
    end
  end

  state_e state;
  entry_t out_q;
  entry_t skid_q;
  logic   out_valid;
  logic   ready_q;
  logic   accept;
  logic   retire;

  assign accept = i_valid && ready_q && clk_en;
  assign retire = out_valid && i_ready && clk_en;

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: both entry registers are cleared on reset, flush and drain because
  // the outputs must read all-zero whenever nothing valid is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      ready_q   <= 1'b1;
    end else if (clk_en) begin
      if (i_flush) begin
        state     <= EMPTY;
        out_q     <= '0;
        skid_q    <= '0;
        out_valid <= 1'b0;
        ready_q   <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              out_q     <= dec;
              out_valid <= 1'b1;
              state     <= ONE;
            end
          end
          ONE: begin
            if (accept && retire) begin
              out_q <= dec;
            end else if (accept) begin
              skid_q  <= dec;
              state   <= FULL;
              ready_q <= 1'b0;
            end else if (retire) begin
              out_q     <= '0;
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
          end
          FULL: begin
            // The skid entry is younger, so it becomes the next output.
            if (retire) begin
              out_q   <= skid_q;
              skid_q  <= '0;
              state   <= ONE;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state     <= EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            ready_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = out_valid;
  assign o_pc      = out_q.pc;
  assign o_opcode  = out_q.opcode;
  assign o_funct7  = out_q.funct7;
  assign o_funct3  = out_q.funct3;
  assign o_rs1     = out_q.rs1;
  assign o_rs2     = out_q.rs2;
  assign o_rd      = out_q.rd;
  assign o_imm     = out_q.imm;
  assign o_type    = out_q.typ;
  assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table streamed at full rate,
// then hand-written backpressure, flush, reset and clock-enable sequences.
module tb_decode_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            clk_en;
  logic            i_flush;
  logic            i_valid;
  logic            i_ready;
  logic [31:0]     i_instruction;
  logic [XLEN-1:0] i_pc;

  logic            o_ready, o_valid, o_illegal;
  logic [XLEN-1:0] o_pc, o_imm;
  logic [6:0]      o_opcode, o_funct7;
  logic [2:0]      o_funct3, o_type;
  logic [4:0]      o_rs1, o_rs2, o_rd;

  logic            n_ready, n_valid, n_illegal;
  logic [XLEN-1:0] n_pc, n_imm;
  logic [6:0]      n_opcode, n_funct7;
  logic [2:0]      n_funct3, n_type;
  logic [4:0]      n_rs1, n_rs2, n_rd;

  decode_stage #(.XLEN(XLEN), .EN_M(1'b1), .EN_SYSTEM(1'b1)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_instruction(i_instruction),
    .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
    .o_opcode(o_opcode), .o_funct7(o_funct7), .o_funct3(o_funct3),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm),
    .o_type(o_type), .o_illegal(o_illegal)
  );

  // Same stream into a core without the M extension.
  decode_stage #(.XLEN(XLEN), .EN_M(1'b0), .EN_SYSTEM(1'b1)) dut_nom (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(n_ready), .i_instruction(i_instruction),
    .i_pc(i_pc), .o_valid(n_valid), .i_ready(i_ready), .o_pc(n_pc),
    .o_opcode(n_opcode), .o_funct7(n_funct7), .o_funct3(n_funct3),
    .o_rs1(n_rs1), .o_rs2(n_rs2), .o_rd(n_rd), .o_imm(n_imm),
    .o_type(n_type), .o_illegal(n_illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  typ;
    logic        m_ext;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] inst, input logic [2:0] typ,
                              input logic m_ext, input logic [6:0] f7,
                              input logic [2:0] f3, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm);
    vec_t v;
    v.inst = inst; v.typ = typ; v.m_ext = m_ext; v.f7 = f7; v.f3 = f3;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm;
    return v;
  endfunction

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic put(input logic [31:0] inst, input logic [31:0] pc);
    i_valid       = 1'b1;
    i_instruction = inst;
    i_pc          = pc;
  endtask

  function automatic logic [31:0] addi_k(input int k);
    return (32'(k) << 20) | 32'h0000_0093;
  endfunction

  initial begin
    vec_t v;
    logic [24:0] fields, exp_fields;

    //            inst          typ m  f7     f3    rs1 rs2 rd  imm
    vecs[0]  = mk(32'hFFF10093, 2, 0, 7'h00, 3'd0, 2, 0, 1,  32'hFFFFFFFF);
    vecs[1]  = mk(32'hFE000EE3, 4, 0, 7'h00, 3'd0, 0, 0, 0,  32'hFFFFFFFC);
    vecs[2]  = mk(32'h00000000, 0, 0, 7'h00, 3'd0, 0, 0, 0,  32'h0);
    vecs[3]  = mk(32'h022081B3, 1, 1, 7'h01, 3'd0, 1, 2, 3,  32'h0);
    vecs[4]  = mk(32'h123452B7, 5, 0, 7'h00, 3'd0, 0, 0, 5,  32'h12345000);
    vecs[5]  = mk(32'h80000517, 5, 0, 7'h00, 3'd0, 0, 0, 10, 32'h80000000);
    vecs[6]  = mk(32'hFF9FF0EF, 6, 0, 7'h00, 3'd0, 0, 0, 1,  32'hFFFFFFF8);
    vecs[7]  = mk(32'h00512423, 3, 0, 7'h00, 3'd2, 2, 5, 0,  32'h00000008);
    vecs[8]  = mk(32'hFE100FA3, 3, 0, 7'h00, 3'd0, 0, 1, 0,  32'hFFFFFFFF);
    vecs[9]  = mk(32'h402081B3, 1, 0, 7'h20, 3'd0, 1, 2, 3,  32'h0);
    vecs[10] = mk(32'h402091B3, 0, 0, 7'h00, 3'd0, 0, 0, 0,  32'h0);
    vecs[11] = mk(32'h40315093, 2, 0, 7'h00, 3'd5, 2, 0, 1,  32'h00000403);
    vecs[12] = mk(32'h04311093, 0, 0, 7'h00, 3'd0, 0, 0, 0,  32'h0);
    vecs[13] = mk(32'h00013083, 0, 0, 7'h00, 3'd0, 0, 0, 0,  32'h0);
    vecs[14] = mk(32'hFFC12083, 2, 0, 7'h00, 3'd2, 2, 0, 1,  32'hFFFFFFFC);
    vecs[15] = mk(32'h00002063, 0, 0, 7'h00, 3'd0, 0, 0, 0,  32'h0);
    vecs[16] = mk(32'h000100E7, 2, 0, 7'h00, 3'd0, 2, 0, 1,  32'h0);
    vecs[17] = mk(32'h000110E7, 0, 0, 7'h00, 3'd0, 0, 0, 0,  32'h0);
    vecs[18] = mk(32'h00000092, 0, 0, 7'h00, 3'd0, 0, 0, 0,  32'h0);
    vecs[19] = mk(32'h00000073, 2, 0, 7'h00, 3'd0, 0, 0, 0,  32'h0);
    vecs[20] = mk(32'h00513423, 0, 0, 7'h00, 3'd0, 0, 0, 0,  32'h0);
    vecs[21] = mk(32'h002081BB, 0, 0, 7'h00, 3'd0, 0, 0, 0,  32'h0);

    rst = 1'b1; clk_en = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_instruction = '0; i_pc = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset o_valid", 64'(o_valid), 64'd0);
    check("reset o_ready", 64'(o_ready), 64'd1);
    check("reset o_pc",    64'(o_pc),    64'd0);
    rst = 1'b0;

    // Full-rate stream: each vector is checked one cycle after it is driven.
    i_ready = 1'b1;
    put(vecs[0].inst, 32'h1000);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      v = vecs[i];
      fields     = {o_funct7, o_funct3, o_rs1, o_rs2, o_rd};
      exp_fields = {v.f7, v.f3, v.rs1, v.rs2, v.rd};
      check($sformatf("vec%0d o_valid", i),   64'(o_valid),   64'd1);
      check($sformatf("vec%0d o_ready", i),   64'(o_ready),   64'd1);
      check($sformatf("vec%0d o_pc", i),      64'(o_pc),      64'(32'h1000 + 32'(4 * i)));
      check($sformatf("vec%0d o_opcode", i),  64'(o_opcode),  64'(v.inst[6:0]));
      check($sformatf("vec%0d o_type", i),    64'(o_type),    64'(v.typ));
      check($sformatf("vec%0d o_illegal", i), 64'(o_illegal), 64'(v.typ == 3'd0));
      check($sformatf("vec%0d o_imm", i),     64'(o_imm),     64'(v.imm));
      check($sformatf("vec%0d fields", i),    64'(fields),    64'(exp_fields));
      check($sformatf("vec%0d nom_illegal", i), 64'(n_illegal), 64'((v.typ == 3'd0) || v.m_ext));
      check($sformatf("vec%0d nom_type", i),  64'(n_type),    64'(v.m_ext ? 3'd0 : v.typ));
      if (i < NV - 1) put(vecs[i+1].inst, 32'h1000 + 32'(4 * (i + 1)));
      else i_valid = 1'b0;
    end
    @(negedge clk);
    check("drain o_valid", 64'(o_valid), 64'd0);
    check("drain o_imm",   64'(o_imm),   64'd0);
    check("drain o_pc",    64'(o_pc),    64'd0);

    // Backpressure: A and B fill the stage, C waits, then all three drain.
    i_ready = 1'b0;
    put(addi_k(1), 32'h2000);
    @(negedge clk);
    put(addi_k(2), 32'h2004);
    @(negedge clk);
    check("bp full o_ready", 64'(o_ready), 64'd0);
    check("bp full o_pc",    64'(o_pc),    64'h2000);
    put(addi_k(3), 32'h2008);
    @(negedge clk);
    check("bp hold o_pc",    64'(o_pc),    64'h2000);
    check("bp hold o_imm",   64'(o_imm),   64'd1);
    check("bp hold o_ready", 64'(o_ready), 64'd0);
    i_ready = 1'b1;
    @(negedge clk);
    check("bp B o_pc",    64'(o_pc),    64'h2004);
    check("bp B o_imm",   64'(o_imm),   64'd2);
    check("bp B o_ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    i_valid = 1'b0;
    check("bp C o_pc",    64'(o_pc),    64'h2008);
    check("bp C o_imm",   64'(o_imm),   64'd3);
    check("bp C o_valid", 64'(o_valid), 64'd1);
    @(negedge clk);
    check("bp empty o_valid", 64'(o_valid), 64'd0);

    // Flush from FULL.
    i_ready = 1'b0;
    put(addi_k(4), 32'h2100);
    @(negedge clk);
    put(addi_k(5), 32'h2104);
    @(negedge clk);
    check("pre-flush o_ready", 64'(o_ready), 64'd0);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush full o_valid", 64'(o_valid), 64'd0);
    check("flush full o_ready", 64'(o_ready), 64'd1);
    check("flush full o_pc",    64'(o_pc),    64'd0);

    // Flush from ONE drops the same-cycle accept.
    put(addi_k(6), 32'h2200);
    @(negedge clk);
    put(addi_k(7), 32'h2204);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush accept o_valid", 64'(o_valid), 64'd0);
    check("flush accept o_imm",   64'(o_imm),   64'd0);

    // Reset from FULL, with clk_en low, clears everything.
    put(addi_k(8), 32'h2300);
    @(negedge clk);
    put(addi_k(9), 32'h2304);
    @(negedge clk);
    i_valid = 1'b0;
    clk_en  = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    clk_en = 1'b1;
    check("rst full o_valid",   64'(o_valid),   64'd0);
    check("rst full o_ready",   64'(o_ready),   64'd1);
    check("rst full o_pc",      64'(o_pc),      64'd0);
    check("rst full o_imm",     64'(o_imm),     64'd0);
    check("rst full o_opcode",  64'(o_opcode),  64'd0);
    check("rst full o_type",    64'(o_type),    64'd0);
    check("rst full o_rd",      64'(o_rd),      64'd0);

    // Clock enable low freezes the stage while both sides are willing.
    put(addi_k(10), 32'h3000);
    @(negedge clk);
    clk_en  = 1'b0;
    i_ready = 1'b1;
    put(addi_k(11), 32'h3004);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("cken%0d o_pc", c),    64'(o_pc),    64'h3000);
      check($sformatf("cken%0d o_valid", c), 64'(o_valid), 64'd1);
      check($sformatf("cken%0d o_imm", c),   64'(o_imm),   64'd10);
    end
    clk_en = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    check("cken resume o_pc",  64'(o_pc),  64'h3004);
    check("cken resume o_imm", 64'(o_imm), 64'd11);
    @(negedge clk);
    check("cken drain o_valid", 64'(o_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32I/RV64I instruction decode stage with a valid/ready handshake on both sides.
- Sits between fetch and register read/execute.
- Accepts an instruction plus PC and produces the decoded fields, a sign-extended XLEN immediate, a format tag and an illegal flag one cycle later.
- A 2-entry skid buffer gives full throughput under backpressure; flush discards all in-flight entries.

Parameters:
- XLEN, 32, datapath width (32 or 64). Sets PC/immediate width and which RV64 opcodes/funct3 values are legal.
- EN_M, 1, when 1, OP/OP-32 with funct7=0000001 (M extension) is legal.
- EN_SYSTEM, 1, when 1, opcode 1110011 is legal (I-format); otherwise it is illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clk_en  in  1  stage enable; when 0 all state holds and no transfer occurs on either side
- i_flush  in  1  discard all held entries
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept; registered, equals ~skid_full
- i_instruction  in  32  raw instruction
- i_pc  in  XLEN  instruction address
- o_valid  out  1  decoded entry valid
- i_ready  in  1  downstream accepts
- o_pc  out  XLEN  PC of decoded entry
- o_opcode  out  7  inst[6:0]
- o_funct7  out  7  inst[31:25]; R only, else 0
- o_funct3  out  3  inst[14:12]; R/I/S/B, else 0
- o_rs1, o_rs2, o_rd  out  5 each  register indices; 0 where the format has no such field
- o_imm  out  XLEN  sign-extended immediate; 0 for R
- o_type  out  3  0 ERROR, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J
- o_illegal  out  1  entry is an illegal instruction

Behaviour:
- Handshakes:
  - Accept when i_valid & o_ready & clk_en.
  - Retire when o_valid & i_ready & clk_en.
  - Decode is combinational on i_instruction; the result is captured into the output register (or the skid register) at accept.
- Latency:
  - 1 cycle from accept to o_valid.
  - Throughput 1/cycle when i_ready=1.
- States (entry count):
  - EMPTY: accept -> ONE.
  - ONE: accept & ~retire -> FULL (entry goes to skid); accept & retire -> ONE (output register reloads); retire only -> EMPTY.
  - FULL: o_ready=0; retire -> ONE (skid moves to output register).
- Ordering: strictly FIFO. The skid entry is always younger than the output entry.
- o_ready is registered: 1 in EMPTY/ONE, 0 in FULL. Never combinationally dependent on i_ready.
- Flush: i_flush=1 on a clock edge with clk_en=1 -> EMPTY, o_valid=0 next cycle. Any same-cycle accept is dropped. Flush has priority over accept/retire.
- Reset: rst=1 -> EMPTY and all outputs 0, o_ready=1 after the edge. This holds regardless of clk_en or an in-progress transfer.
- Output hold: while o_valid=1 & ~i_ready, all outputs are stable. While o_valid=0, outputs are all-zero.
- Immediates, sign-extended from inst[31] to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- Format map:
  - R: 0110011, plus 0111011 if XLEN=64.
  - I: 0010011, 0000011, 1100111, 1110011, plus 0011011 if XLEN=64.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
- Illegal (o_type=0, o_illegal=1, all field outputs 0, o_pc/o_opcode still carried):
  - inst[1:0]!=11, or unmapped opcode.
  - R with funct7 not in {0000000, 0100000 (funct3 000/101 only), 0000001 if EN_M}.
  - OP-IMM shifts: XLEN=32 needs inst[31:25] in {0000000, 0100000 (srai)}; XLEN=64 checks inst[31:26].
  - Load funct3 in {011,110} when XLEN=32, or 111 always.
  - Store funct3 >= 011 when XLEN=32, or >= 100 always.
  - Branch funct3 010/011.
  - JALR funct3 != 000.
  - SYSTEM when EN_SYSTEM=0.
- Illegal entries flow through the handshake like legal ones; they are never dropped.

Test Plan:
- Single decode: XLEN=32, accept 0xFFF10093 (addi x1,x2,-1) at cycle 0 -> cycle 1: o_valid=1, o_type=2, rs1=2, rd=1, rs2=0, o_imm=0xFFFFFFFF, o_illegal=0.
- Branch immediate: 0xFE000EE3 (beq x0,x0,-4) -> o_type=4, o_imm=0xFFFFFFFC, o_rd=0, o_funct3=0.
- Backpressure: i_ready=0, stream A,B,C with i_valid=1 -> A,B accepted; o_ready=0 from the cycle after B; C held. Raise i_ready -> A,B,C retire in order on consecutive cycles with no bubble.
- Illegal: 0x00000000 -> o_illegal=1, o_type=0, o_imm=0, o_pc carried. 0x022081B3 (mul) with EN_M=0 -> illegal; with EN_M=1 -> o_type=1, funct7=0000001, rd=3.
- Flush/reset: in FULL, assert i_flush -> o_valid=0 and o_ready=1 next cycle. Repeat with rst in place of i_flush -> all outputs 0.
- clk_en=0 for 3 cycles with i_valid=1 and i_ready=1 -> no accept or retire, outputs and state unchanged. Resumes correctly when clk_en=1.
